// File: rtl/tqvp_gera_gray_engine_if.sv
// Register-bus bundle for the TinyQV byte-peripheral slot.
interface tqvp_gera_gray_engine_if;
  logic [3:0] address;
  logic       data_write;
  logic [7:0] data_in;
  logic [7:0] data_out;

  modport master (output address, output data_write, output data_in, input data_out);
  modport slave  (input address, input data_write, input data_in, output data_out);
endinterface

// File: rtl/tqvp_gera_gray_engine.sv
// Gray-code engine: bit-serial binary<->Gray converter plus prescaled up/down
// Gray counter, all exposed through an 8-bit register bus.
module tqvp_gera_gray_engine #(
  parameter int WIDTH      = 16,
  parameter int PRESCALE_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  tqvp_gera_gray_engine_if.slave bus
);
  localparam int N     = WIDTH / 8;
  localparam int IDX_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CONV, DONE, COUNT} state_t;

  state_t                  state_reg, state_next;
  logic [WIDTH-1:0]        operand_reg, operand_next;
  logic [WIDTH-1:0]        result_reg, result_next;
  logic [WIDTH-1:0]        count_reg, count_next;
  logic [IDX_W-1:0]        idx_reg, idx_next;
  logic                    done_reg, done_next;
  logic                    g2b_reg, g2b_next;
  logic                    dir_reg, dir_next;
  logic [PRESCALE_W-1:0]   presc_cnt_reg, presc_cnt_next;
  logic [PRESCALE_W-1:0]   period_reg, period_next;
  logic [PRESCALE_W-1:0]   prescale_reg, prescale_next;
  logic [1:0]              outsel_reg, outsel_next;

  logic                    unused_ok;
  assign unused_ok = &{1'b0, ui_in, 1'b0};

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] v);
    return v ^ (v >> 1);
  endfunction

  // Bit i of either conversion depends only on bit i+1 of operand or of the
  // partially built result; shifting right supplies the implicit zero at WIDTH.
  logic [WIDTH-1:0] op_sh, res_sh, conv_bits, idx_sel;
  assign op_sh  = operand_reg >> 1;
  assign res_sh = result_reg >> 1;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_conv
    assign idx_sel[gi]   = (idx_reg == IDX_W'(gi));
    assign conv_bits[gi] = operand_reg[gi] ^ (g2b_reg ? res_sh[gi] : op_sh[gi]);
  end

  logic       wr_en, wr_ctrl, engaged;
  logic [3:0] addr;
  logic [7:0] din;
  logic [15:0] presc16;
  assign wr_en   = bus.data_write;
  assign addr    = bus.address;
  assign din     = bus.data_in;
  assign wr_ctrl = wr_en && (addr == 4'h0);
  assign engaged = (state_reg == CONV) || (state_reg == COUNT);

  always_comb begin
    state_next     = state_reg;
    operand_next   = operand_reg;
    result_next    = result_reg;
    count_next     = count_reg;
    idx_next       = idx_reg;
    done_next      = done_reg;
    g2b_next       = g2b_reg;
    dir_next       = dir_reg;
    presc_cnt_next = presc_cnt_reg;
    period_next    = period_reg;
    outsel_next    = outsel_reg;
    presc16        = 16'(prescale_reg);

    unique case (state_reg)
      CONV: begin
        result_next = result_reg | (conv_bits & idx_sel);
        if (idx_reg == '0) begin
          state_next = DONE;
          done_next  = 1'b1;
        end else begin
          idx_next = idx_reg - IDX_W'(1);
        end
      end
      COUNT: begin
        // Period is re-latched at each wrap so PRESCALE edits apply cleanly.
        if (presc_cnt_reg == period_reg) begin
          presc_cnt_next = '0;
          period_next    = prescale_reg;
          count_next     = dir_reg ? count_reg - WIDTH'(1) : count_reg + WIDTH'(1);
          result_next    = to_gray(count_next);
        end else begin
          presc_cnt_next = presc_cnt_reg + PRESCALE_W'(1);
        end
      end
      default: ;
    endcase

    if (wr_ctrl) begin
      if (din[1:0] == 2'b00) begin
        state_next     = IDLE;
        result_next    = '0;
        done_next      = 1'b0;
        count_next     = '0;
        presc_cnt_next = '0;
      end else if (din[2] && !engaged) begin
        if (din[1:0] == 2'b11) begin
          state_next     = COUNT;
          count_next     = operand_reg;
          result_next    = to_gray(operand_reg);
          presc_cnt_next = '0;
          period_next    = prescale_reg;
          dir_next       = din[3];
        end else begin
          state_next  = CONV;
          idx_next    = IDX_W'(WIDTH - 1);
          done_next   = 1'b0;
          result_next = '0;
          g2b_next    = din[1];
        end
      end
    end

    if (wr_en && !engaged) begin
      for (int k = 0; k < N; k++) begin
        if (addr == 4'(k + 1)) operand_next[k*8 +: 8] = din;
      end
    end

    if (wr_en && addr == 4'hA) presc16[7:0]  = din;
    if (wr_en && addr == 4'hB) presc16[15:8] = din;
    prescale_next = PRESCALE_W'(presc16);
    if (wr_en && addr == 4'hC) outsel_next = din[1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      operand_reg   <= '0;
      result_reg    <= '0;
      count_reg     <= '0;
      idx_reg       <= '0;
      done_reg      <= 1'b0;
      g2b_reg       <= 1'b0;
      dir_reg       <= 1'b0;
      presc_cnt_reg <= '0;
      period_reg    <= '0;
      prescale_reg  <= '0;
      outsel_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      operand_reg   <= operand_next;
      result_reg    <= result_next;
      count_reg     <= count_next;
      idx_reg       <= idx_next;
      done_reg      <= done_next;
      g2b_reg       <= g2b_next;
      dir_reg       <= dir_next;
      presc_cnt_reg <= presc_cnt_next;
      period_reg    <= period_next;
      prescale_reg  <= prescale_next;
      outsel_reg    <= outsel_next;
    end
  end

  // Byte lanes beyond WIDTH read as zero.
  logic [7:0] op_byte  [4];
  logic [7:0] res_byte [4];
  for (genvar gi = 0; gi < 4; gi++) begin : g_bytes
    if (gi < N) begin : g_live
      assign op_byte[gi]  = operand_reg[gi*8 +: 8];
      assign res_byte[gi] = result_reg[gi*8 +: 8];
    end else begin : g_zero
      assign op_byte[gi]  = 8'h00;
      assign res_byte[gi] = 8'h00;
    end
  end

  logic [15:0] presc_rd;
  assign presc_rd = 16'(prescale_reg);
  assign uo_out   = res_byte[outsel_reg];

  always_comb begin
    bus.data_out = 8'h00;
    case (addr)
      4'h1: bus.data_out = op_byte[0];
      4'h2: bus.data_out = op_byte[1];
      4'h3: bus.data_out = op_byte[2];
      4'h4: bus.data_out = op_byte[3];
      4'h5: bus.data_out = res_byte[0];
      4'h6: bus.data_out = res_byte[1];
      4'h7: bus.data_out = res_byte[2];
      4'h8: bus.data_out = res_byte[3];
      4'h9: bus.data_out = {5'b0, state_reg == COUNT, done_reg, state_reg == CONV};
      4'hA: bus.data_out = presc_rd[7:0];
      4'hB: bus.data_out = presc_rd[15:8];
      4'hC: bus.data_out = {6'b0, outsel_reg};
      default: bus.data_out = 8'h00;
    endcase
  end
endmodule

// File: tb/tb_tqvp_gera_gray_engine.sv
// Scoreboard bench for the Gray engine at WIDTH=16: stimulus queues expected
// reads, a negedge monitor pops and compares them.
module tb_tqvp_gera_gray_engine;
  logic       clk;
  logic       rst_n;
  logic [7:0] ui_in;
  logic [7:0] uo_out;

  tqvp_gera_gray_engine_if bus();

  tqvp_gera_gray_engine #(.WIDTH(16), .PRESCALE_W(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    bit         is_uo;
    logic [7:0] exp;
  } exp_t;

  exp_t sb[$];
  logic chk_valid;
  int   n_vec;
  int   n_err;

  always @(negedge clk) begin
    if (chk_valid) begin
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard_underflow: got a check request with no expected value");
      end else begin
        exp_t it;
        logic [7:0] act;
        it  = sb.pop_front();
        act = it.is_uo ? uo_out : bus.data_out;
        n_vec++;
        if (act !== it.exp) begin
          n_err++;
          $display("FAIL %s: got 0x%02h expected 0x%02h", it.name, act, it.exp);
        end else begin
          $display("ok   %s: 0x%02h", it.name, act);
        end
      end
    end
  end

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    bus.address    = a;
    bus.data_in    = d;
    bus.data_write = 1'b1;
    @(posedge clk); #1;
    bus.data_write = 1'b0;
  endtask

  task automatic chk(input logic [3:0] a, input logic [7:0] e, input string nm);
    exp_t it;
    it.name = nm; it.is_uo = 1'b0; it.exp = e;
    bus.address = a;
    sb.push_back(it);
    chk_valid = 1'b1;
    @(posedge clk); #1;
    chk_valid = 1'b0;
  endtask

  task automatic chk_uo(input logic [7:0] e, input string nm);
    exp_t it;
    it.name = nm; it.is_uo = 1'b1; it.exp = e;
    sb.push_back(it);
    chk_valid = 1'b1;
    @(posedge clk); #1;
    chk_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Reset pulse with a concurrent OUTSEL write that must lose to reset.
  task automatic rst_pulse();
    rst_n          = 1'b0;
    bus.address    = 4'hC;
    bus.data_in    = 8'h03;
    bus.data_write = 1'b1;
    @(posedge clk); #1;
    rst_n          = 1'b1;
    bus.data_write = 1'b0;
  endtask

  task automatic chk_all_zero(input string nm);
    for (int a = 0; a < 16; a++) chk(4'(a), 8'h00, $sformatf("%s_addr%0d", nm, a));
    chk_uo(8'h00, {nm, "_uo"});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0; n_err = 0; chk_valid = 1'b0;
    ui_in = 8'h5A;
    bus.address = 4'h0; bus.data_in = 8'h00; bus.data_write = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    chk_all_zero("reset");

    // bin->gray 0x1234 -> 0x1B2E with busy/done timing
    wr(4'h1, 8'h34); wr(4'h2, 8'h12); wr(4'h0, 8'h05);
    chk(4'h9, 8'h01, "b2g_busy_first");
    idle(14);
    chk(4'h9, 8'h01, "b2g_busy_last");
    chk(4'h9, 8'h02, "b2g_done");
    chk(4'h5, 8'h2E, "b2g_res0");
    chk(4'h6, 8'h1B, "b2g_res1");
    chk_uo(8'h2E, "b2g_uo_sel0");
    wr(4'hC, 8'h01);
    chk_uo(8'h1B, "b2g_uo_sel1");
    chk(4'hC, 8'h01, "outsel_rd");
    wr(4'hC, 8'h00);
    chk(4'h7, 8'h00, "res_byte2_zero");
    chk(4'h3, 8'h00, "op_byte2_zero");
    chk(4'h0, 8'h00, "ctrl_rd_zero");

    // gray->bin
    wr(4'h1, 8'h2E); wr(4'h2, 8'h1B); wr(4'h0, 8'h06);
    idle(16);
    chk(4'h9, 8'h02, "g2b_done");
    chk(4'h5, 8'h34, "g2b_res0");
    chk(4'h6, 8'h12, "g2b_res1");
    wr(4'h1, 8'h00); wr(4'h2, 8'h80); wr(4'h0, 8'h06);
    idle(16);
    chk(4'h5, 8'hFF, "g2b_8000_res0");
    chk(4'h6, 8'hFF, "g2b_8000_res1");

    // Restart and operand write during CONV are ignored
    wr(4'h1, 8'h34); wr(4'h2, 8'h12); wr(4'h0, 8'h05);
    idle(4);
    wr(4'h0, 8'h05);
    wr(4'h1, 8'hFF);
    idle(10);
    chk(4'h9, 8'h02, "busy_ign_done");
    chk(4'h5, 8'h2E, "busy_ign_res0");
    chk(4'h6, 8'h1B, "busy_ign_res1");
    chk(4'h1, 8'h34, "busy_ign_op0");

    // Clear at T+8 aborts conversion
    wr(4'h0, 8'h05);
    idle(7);
    wr(4'h0, 8'h00);
    chk(4'h9, 8'h00, "clear_status");
    chk(4'h5, 8'h00, "clear_res0");
    chk(4'h6, 8'h00, "clear_res1");
    chk(4'h1, 8'h34, "clear_op_kept");

    // Up counter from 0xFFFF, PRESCALE=2: wraps to 0 at T+4, 1 at T+7
    wr(4'h1, 8'hFF); wr(4'h2, 8'hFF); wr(4'hA, 8'h02); wr(4'hB, 8'h00);
    chk(4'hA, 8'h02, "presc_lo_rd");
    wr(4'h0, 8'h07);
    chk(4'h5, 8'h00, "cnt_seed_res0");
    chk(4'h6, 8'h80, "cnt_seed_res1");
    chk(4'h6, 8'h80, "cnt_hold_res1");
    chk(4'h6, 8'h00, "cnt_wrap_res1");
    chk(4'h5, 8'h00, "cnt_wrap_res0a");
    chk(4'h5, 8'h00, "cnt_wrap_res0b");
    chk(4'h5, 8'h01, "cnt_one_res0");
    chk(4'h9, 8'h04, "cnt_status");
    wr(4'h0, 8'h00);
    chk(4'h9, 8'h00, "cnt_clear_status");
    chk(4'h5, 8'h00, "cnt_clear_res0");

    // Down counter from 0 -> 0xFFFF -> gray 0x8000 after first tick
    wr(4'h1, 8'h00); wr(4'h2, 8'h00); wr(4'h0, 8'h0F);
    chk(4'h6, 8'h00, "dn_seed_res1");
    chk(4'h6, 8'h00, "dn_hold1_res1");
    chk(4'h6, 8'h00, "dn_hold2_res1");
    chk(4'h6, 8'h80, "dn_wrap_res1");
    chk(4'h5, 8'h00, "dn_wrap_res0");
    wr(4'h0, 8'h00);

    // PRESCALE=0 ticks every cycle: gray 0,1,3,2,6
    wr(4'hA, 8'h00); wr(4'h0, 8'h07);
    chk(4'h5, 8'h00, "p0_g0");
    chk(4'h5, 8'h01, "p0_g1");
    chk(4'h5, 8'h03, "p0_g2");
    chk(4'h5, 8'h02, "p0_g3");
    chk(4'h5, 8'h06, "p0_g4");
    wr(4'hA, 8'h05);
    chk(4'hA, 8'h05, "presc_wr_counting");
    wr(4'hB, 8'hAB);
    chk(4'hB, 8'hAB, "presc_hi_rd");

    // Reset mid-COUNT, with a colliding write
    rst_pulse();
    chk_all_zero("rst_count");

    // Reset mid-CONV
    wr(4'h1, 8'h34); wr(4'h2, 8'h12); wr(4'hC, 8'h01); wr(4'h0, 8'h05);
    idle(5);
    chk(4'h9, 8'h01, "pre_rst_busy");
    rst_pulse();
    chk_all_zero("rst_conv");

    for (int i = 0; i < 5 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d expected values left, required 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/tqvp_gera_gray_engine.md
# tqvp_gera_gray_engine

Parametrised Gray-code engine for the TinyQV byte-peripheral slot. It converts a multi-byte operand between binary and Gray code using a bit-serial sequencer with busy/done status. It also runs as a prescaled up/down Gray counter. Every operand and result byte is reachable through the 8-bit register bus, and one result byte can be selected onto the output PMOD.

## Interface
- WIDTH, 16, operand/result width in bits; multiple of 8, range 8..32
- PRESCALE_W, 16, width of counter prescaler register; range 1..16
- clk  in  1  TinyQV clock (64 MHz nominal)
- rst_n  in  1  reset, synchronous, active-low
- ui_in  in  8  input PMOD; unused, tied into an unused-signal sink
- uo_out  out  8  result byte selected by OUTSEL
- address  in  4  register address
- data_write  in  1  write strobe; data_in valid when high
- data_in  in  8  write data
- data_out  out  8  read data, combinational from address

## Operation
- Register map (N = WIDTH/8):
  - 0x0 CTRL, write-only; reads 0.
    - bits[1:0] mode: 00 clear/abort, 01 bin->gray, 10 gray->bin, 11 counter.
    - bit2 start.
    - bit3 direction (0 up, 1 down), counter mode only.
  - 0x1..0x4 OPERAND byte 0..3, little-endian, R/W. Bytes ≥ N: writes ignored, reads 0.
  - 0x5..0x8 RESULT byte 0..3, read-only. Bytes ≥ N read 0.
  - 0x9 STATUS, read-only: bit0 busy, bit1 done, bit2 counting; bits[7:3] = 0.
  - 0xA/0xB PRESCALE low/high byte, R/W. Bits above PRESCALE_W are ignored and read 0.
  - 0xC OUTSEL, R/W, bits[1:0]. Selects the RESULT byte driven on uo_out; a byte ≥ N drives 0.
  - Other addresses: writes ignored, reads 0.
- FSM states: IDLE, CONV, DONE, COUNT.
  - CTRL write with mode 00, from any state: state -> IDLE; result, done and count cleared; operand kept.
  - IDLE/DONE + CTRL write, start=1, mode 01/10: state -> CONV, idx <= WIDTH-1, done <= 0, result <= 0.
  - CONV, one result bit per cycle from MSB down:
    - bin->gray: r[i] = op[i] ^ op[i+1], with op[WIDTH] = 0.
    - gray->bin: r[i] = op[i] ^ r[i+1], with r[WIDTH] = 0.
    - After bit 0: state -> DONE, done <= 1.
  - IDLE/DONE + CTRL write, start=1, mode 11: state -> COUNT; count <= operand; result <= gray(operand); prescale counter <= 0; direction latched.
  - COUNT: a tick fires every PRESCALE+1 cycles. On each tick, count <= count ± 1 modulo 2^WIDTH and result <= gray(new count).
  - A CTRL write with start=0 and mode ≠ 00 is ignored.
- Writes while busy (CONV) or counting (COUNT):
  - CTRL with start=1: ignored.
  - OPERAND: ignored.
  - PRESCALE: accepted; takes effect at the next prescaler wrap.
  - OUTSEL: accepted.
- busy = (state == CONV). counting = (state == COUNT). done is sticky until the next accepted start or a clear.

## Timing
- Reset values: uo_out = 0, data_out = 0 for all addresses, state IDLE. Operand, result, count, prescaler, PRESCALE, OUTSEL and direction all 0.
- Start accepted at edge T:
  - busy reads 1 from cycle T+1.
  - Result bit WIDTH-1-k is written at edge T+1+k.
  - done = 1 and busy = 0 from cycle T+WIDTH+1.
  - Conversion latency is exactly WIDTH cycles.
- Counter: result = gray(seed) from cycle T+1. The first tick lands on edge T+PRESCALE+1; later ticks follow every PRESCALE+1 edges.
- PRESCALE = 0: counter ticks every cycle.
- Wrap-around: up from 2^WIDTH-1 gives 0; down from 0 gives 2^WIDTH-1.
- Clear write while in CONV/COUNT: effective at that edge. uo_out and RESULT read 0 from the next cycle.
- rst_n low mid-operation: all state returns to reset values at the next edge, whatever the data_write value.
- Simultaneous reset and write: reset wins.
- uo_out and data_out follow registered state with no added latency. A read in the cycle after a write returns the new value.

## Test plan
- WIDTH=16: write OPERAND 0x34, 0x12; CTRL = 0x05 -> busy for 16 cycles; then done = 1, RESULT = 0x2E, 0x1B (0x1B2E); uo_out = 0x2E with OUTSEL = 0.
- Gray->bin: operand 0x1B2E, CTRL = 0x06 -> result 0x1234 after 16 cycles. Also operand 0x8000 -> 0xFFFF.
- Mid-conversion: CTRL = 0x05 issued again and OPERAND written at cycle T+5 -> both ignored, result unchanged from the first run. CTRL = 0x00 at T+8 -> busy 0, done 0, RESULT 0 at T+9.
- Counter wrap:
  - Seed 0xFFFF, PRESCALE = 2, CTRL = 0x07 -> result 0x8000 from T+1.
  - Result 0x0000 at T+4, then 0x0001 at T+7.
  - Direction down (CTRL = 0x0F) from seed 0 -> 0x8000 after the first tick.
- Reset at any point mid-COUNT and mid-CONV -> every register reads 0 and uo_out = 0 the next cycle. Unmapped addresses 0xD–0xF and RESULT byte 2 with WIDTH=16 read 0.
- WIDTH=8 and WIDTH=32 builds: 0xA5 -> gray 0xF7. For WIDTH=32, 0xDEADBEEF -> 0xB1FB6198 in 32 cycles; a round trip restores the original.
